// File: rtl/lcd_display_sequencer.sv
// Drives the LCD source-mux select, captures the settled value and streams
// it to the character writer as "L:XXXXXXXX" on a periodic refresh.
module lcd_display_sequencer #(
    parameter int unsigned REFRESH_CYCLES = 50000000,
    parameter int unsigned SETTLE_CYCLES  = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_auto_mode,
    input  logic [1:0]  i_manual_sel,
    input  logic        i_refresh_req,
    input  logic [31:0] i_mux_data,
    output logic [1:0]  o_sel,
    output logic        o_char_valid,
    output logic [7:0]  o_char_data,
    output logic [3:0]  o_char_pos,
    input  logic        i_char_ready,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int unsigned TW = $clog2(REFRESH_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] POS_LAST = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TW-1:0]  r_timer;
    logic           r_pending;
    logic           r_first;
    logic [3:0]     r_settle;
    logic [31:0]    r_hold;
    logic [1:0]     r_sel;
    logic           r_valid;
    logic [3:0]     r_pos;

    logic           w_expire;
    logic           w_start;
    logic           w_xfer;
    logic           w_last_xfer;
    logic [1:0]     w_sel_next;
    logic [7:0][3:0] w_nibbles;
    logic [3:0]     w_nib;
    logic [7:0]     w_char;

    assign w_expire    = (r_timer == TIMER_LAST);
    assign w_xfer      = r_valid && i_char_ready;
    assign w_last_xfer = w_xfer && (r_pos == POS_LAST);
    assign w_start     = (r_state == S_IDLE) &&
                         (r_first || w_expire || r_pending || i_refresh_req);

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        o_busy       = 1'b0;
        o_frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_SETTLE;
                    if (r_first)
                        w_sel_next = 2'b00;
                    else if (i_auto_mode)
                        w_sel_next = r_sel + 2'd1;
                    else
                        w_sel_next = i_manual_sel;
                end
            end
            S_SETTLE: begin
                o_busy = 1'b1;
                if (r_settle == SETTLE_LAST)
                    w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                o_busy       = 1'b1;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                o_busy = 1'b1;
                if (w_last_xfer)
                    w_state_next = S_DONE;
            end
            S_DONE: begin
                o_frame_done = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_first   <= 1'b1;
            r_settle  <= 4'd0;
            r_hold    <= 32'd0;
            r_sel     <= 2'b00;
            r_valid   <= 1'b0;
            r_pos     <= 4'd0;
        end else begin
            r_timer <= (w_start || w_expire) ? '0 : r_timer + TW'(1);
            // Requests arriving outside IDLE are remembered for one extra frame
            if (w_start)
                r_pending <= 1'b0;
            else if ((r_state != S_IDLE) && (w_expire || i_refresh_req))
                r_pending <= 1'b1;
            if (w_start)
                r_first <= 1'b0;
            r_sel    <= w_sel_next;
            r_settle <= (r_state == S_SETTLE) ? r_settle + 4'd1 : 4'd0;
            if (r_state == S_CAPTURE) begin
                r_hold  <= i_mux_data;
                r_pos   <= 4'd0;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                if (r_pos == POS_LAST)
                    r_valid <= 1'b0;
                else
                    r_pos <= r_pos + 4'd1;
            end
        end
    end

    assign w_nibbles = r_hold;

    always_comb begin
        w_nib  = w_nibbles[3'(POS_LAST - r_pos)];
        w_char = 8'h00;
        unique case (r_pos)
            4'd0: begin
                unique case (r_sel)
                    2'b00: w_char = 8'h52;
                    2'b01: w_char = 8'h44;
                    2'b10: w_char = 8'h49;
                    2'b11: w_char = 8'h41;
                    default: w_char = 8'h00;
                endcase
            end
            4'd1: w_char = 8'h3A;
            default: begin
                if (w_nib < 4'd10)
                    w_char = 8'h30 + {4'h0, w_nib};
                else
                    w_char = 8'h37 + {4'h0, w_nib};
            end
        endcase
    end

    assign o_sel        = r_sel;
    assign o_char_valid = r_valid;
    assign o_char_pos   = r_pos;
    assign o_char_data  = r_valid ? w_char : 8'h00;

endmodule
